keypad_time_entry: RTL and testbench

- Upstream stage of the BCD down-counter chain in the timer datapath.
- Captures decimal keypad presses into a 4-digit MM:SS BCD buffer.
- Drives the chain's parallel data, its synchronous active-low load strobe, and its count enable.
- Sequences entry / load / run / pause, and returns to idle when the chain reports all-zero.

---
 rtl/keypad_time_entry.sv | 167 ++++++++++++++++
 tb/tb_keypad_time_entry.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_time_entry.sv
// Keypad time-entry front end: captures MM:SS BCD digits and sequences load/run/pause of the down-counter chain.
// Optional raw-key filter enabled by defining KEY_DEBOUNCE_EN (DEBOUNCE_CYCLES stable samples required).
module keypad_time_entry #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clock,
   input  logic        clearn,
   input  logic [9:0]  keypad,
   input  logic        start,
   input  logic        stop,
   input  logic        timer_done,
   output logic [15:0] digits,
   output logic        loadn,
   output logic        count_en,
   output logic [2:0]  digit_count,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENTRY = 2'd1,
      RUN   = 2'd2,
      PAUSE = 2'd3
   } state_t;

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce_cycles
      $error("DEBOUNCE_CYCLES must be at least 1");
   end

   state_t      state_q, state_d;
   logic [15:0] digits_q, digits_d;
   logic [2:0]  count_q, count_d;
   logic        loadn_q, loadn_d;
   logic        start_q, stop_q;
   logic [9:0]  key_src, kq, kqq;
   logic        press;
   logic [3:0]  key_val;
   logic        start_pulse, stop_pulse;

`ifdef KEY_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] STABLE_MAX = CW'(DEBOUNCE_CYCLES);

   logic [9:0]    cand, filt;
   logic [CW-1:0] stable_cnt, stable_next;

   // stable_next counts consecutive identical raw samples, including the one being taken now.
   always_comb begin
      if (keypad != cand)
         stable_next = CW'(1);
      else if (stable_cnt == STABLE_MAX)
         stable_next = stable_cnt;
      else
         stable_next = stable_cnt + 1'b1;
   end

   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         cand       <= '0;
         stable_cnt <= '0;
         filt       <= '0;
      end else begin
         cand       <= keypad;
         stable_cnt <= stable_next;
         if (stable_next == STABLE_MAX)
            filt <= keypad;
      end
   end

   assign key_src = filt;
`else
   assign key_src = keypad;
`endif

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         kq       <= '0;
         kqq      <= '0;
         start_q  <= 1'b0;
         stop_q   <= 1'b0;
         state_q  <= IDLE;
         digits_q <= '0;
         count_q  <= '0;
         loadn_q  <= 1'b1;
      end else begin
         kq       <= key_src;
         kqq      <= kq;
         start_q  <= start;
         stop_q   <= stop;
         state_q  <= state_d;
         digits_q <= digits_d;
         count_q  <= count_d;
         loadn_q  <= loadn_d;
      end
   end

   assign start_pulse = start & ~start_q;
   assign stop_pulse  = stop & ~stop_q;

   // A press is a fresh single key arriving after an all-released sample.
   always_comb begin
      press   = (kqq == '0) && $onehot(kq);
      key_val = '0;
      for (int i = 0; i < 10; i++)
         if (kq[i]) key_val = 4'(i);
   end

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      digits_d = digits_q;
      count_d  = count_q;
      loadn_d  = 1'b1;
      unique case (state_q)
         IDLE: begin
            if (!stop_pulse && !start_pulse && press) begin
               digits_d = {digits_q[11:0], key_val};
               count_d  = count_q + 3'd1;
               state_d  = ENTRY;
            end
         end
         ENTRY: begin
            if (stop_pulse) begin
               digits_d = '0;
               count_d  = '0;
               state_d  = IDLE;
            end else if (start_pulse) begin
               if (digits_q[7:4] > 4'd5)
                  digits_d[7:4] = 4'd5;
               loadn_d = 1'b0;
               state_d = RUN;
            end else if (press && count_q < 3'd4) begin
               digits_d = {digits_q[11:0], key_val};
               count_d  = count_q + 3'd1;
            end
         end
         RUN: begin
            // The chain still reads zero during the load cycle, so timer_done is ignored then.
            if (timer_done && loadn_q) begin
               digits_d = '0;
               count_d  = '0;
               state_d  = IDLE;
            end else if (stop_pulse) begin
               state_d = PAUSE;
            end
         end
         PAUSE: begin
            if (stop_pulse) begin
               digits_d = '0;
               count_d  = '0;
               state_d  = IDLE;
            end else if (start_pulse) begin
               state_d = RUN;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign digits      = digits_q;
   assign loadn       = loadn_q;
   assign count_en    = (state_q == RUN) && loadn_q;
   assign digit_count = count_q;
   assign state       = state_q;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry: directed scenarios plus randomized traffic against a behavioural model.
// Define KEY_DEBOUNCE_EN for both files to exercise the filtered key path.
module tb_keypad_time_entry;

   localparam int DB = 16;
`ifdef KEY_DEBOUNCE_EN
   localparam int HOLD     = DB + 3;
   localparam int HOLD_MAX = 2 * DB;
`else
   localparam int HOLD     = 3;
   localparam int HOLD_MAX = 4;
`endif

   logic        clock = 1'b0;
   logic        clearn = 1'b0;
   logic [9:0]  keypad = '0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        timer_done = 1'b0;
   logic [15:0] digits;
   logic        loadn;
   logic        count_en;
   logic [2:0]  digit_count;
   logic [1:0]  state;

   int vectors = 0;
   int miscompares = 0;
   int loadn_lows = 0;
   bit chk_en = 0;

   keypad_time_entry #(.DEBOUNCE_CYCLES(DB)) dut (
      .clock       (clock),
      .clearn      (clearn),
      .keypad      (keypad),
      .start       (start),
      .stop        (stop),
      .timer_done  (timer_done),
      .digits      (digits),
      .loadn       (loadn),
      .count_en    (count_en),
      .digit_count (digit_count),
      .state       (state)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_mode;      // 0 idle, 1 entry, 2 run, 3 pause
   int          m_ent[$];    // digits typed, oldest first (at most four)
   bit          m_load;      // true during the single load cycle
   logic [9:0]  m_s1, m_s2;  // the last two key samples the press rule looks at
   bit          m_pstart, m_pstop;
`ifdef KEY_DEBOUNCE_EN
   logic [9:0]  m_hist[$];
   logic [9:0]  m_filt;
`endif

   function automatic logic [15:0] m_digits();
      logic [15:0] v = '0;
      for (int i = 0; i < 4; i++)
         if (m_ent.size() > i) v = v | (16'(m_ent[m_ent.size() - 1 - i]) << (4 * i));
      return v;
   endfunction

   task automatic m_reset();
      m_mode = 0;
      m_ent.delete();
      m_load = 0;
      m_s1 = '0;
      m_s2 = '0;
      m_pstart = 0;
      m_pstop = 0;
`ifdef KEY_DEBOUNCE_EN
      m_hist.delete();
      m_filt = '0;
`endif
   endtask

   initial m_reset();

   always @(posedge clock or negedge clearn) begin : model
      bit press, sp, tp, was_load, all_same;
      int key;
      if (!clearn) begin
         m_reset();
      end else begin
         press = ($countones(m_s1) == 1) && (m_s2 == '0);
         key = 0;
         for (int i = 0; i < 10; i++) if (m_s1[i]) key = i;
         sp = start && !m_pstart;
         tp = stop && !m_pstop;
         was_load = m_load;
         m_load = 0;
         case (m_mode)
            0: if (!tp && !sp && press) begin m_ent.push_back(key); m_mode = 1; end
            1: begin
               if (tp) begin m_ent.delete(); m_mode = 0; end
               else if (sp) begin
                  if (m_ent.size() >= 2 && m_ent[m_ent.size() - 2] > 5) m_ent[m_ent.size() - 2] = 5;
                  m_load = 1;
                  m_mode = 2;
               end else if (press && m_ent.size() < 4) m_ent.push_back(key);
            end
            2: begin
               if (timer_done && !was_load) begin m_ent.delete(); m_mode = 0; end
               else if (tp) m_mode = 3;
            end
            default: begin
               if (tp) begin m_ent.delete(); m_mode = 0; end
               else if (sp) m_mode = 2;
            end
         endcase
         m_pstart = start;
         m_pstop = stop;
         m_s2 = m_s1;
`ifdef KEY_DEBOUNCE_EN
         m_s1 = m_filt;
         m_hist.push_back(keypad);
         if (m_hist.size() > DB) void'(m_hist.pop_front());
         all_same = (m_hist.size() == DB);
         foreach (m_hist[i]) if (m_hist[i] != keypad) all_same = 0;
         if (all_same) m_filt = keypad;
`else
         all_same = 0;
         m_s1 = keypad;
`endif
      end
   end

   // Compare every cycle against the model, away from the active edge.
   always @(negedge clock) begin
      if (chk_en) begin
         check("digits", 32'(digits), 32'(m_digits()));
         check("digit_count", 32'(digit_count), 32'(m_ent.size()));
         check("state", 32'(state), 32'(m_mode));
         check("loadn", 32'(loadn), 32'(!m_load));
         check("count_en", 32'(count_en), 32'(m_mode == 2 && !m_load));
         if (!loadn) loadn_lows++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic press_key(input int k);
      keypad = 10'b1 << k;
      cyc(HOLD);
      keypad = '0;
      cyc(HOLD);
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      cyc(1);
   endtask

   initial begin : stim
      int hold;
      int r;
      int lows_before;

      cyc(2);
      check("reset_digits", 32'(digits), 32'h0);
      check("reset_loadn", 32'(loadn), 32'h1);
      check("reset_state", 32'(state), 32'h0);
      clearn = 1'b1;
      chk_en = 1;
      cyc(1);

      // four keys fill the buffer; a fifth is ignored
      press_key(1); press_key(2); press_key(3); press_key(0);
      check("t1_digits", 32'(digits), 32'h1230);
      check("t1_count", 32'(digit_count), 32'd4);
      check("t1_state", 32'(state), 32'd1);
      press_key(7);
      check("t1_fifth_key", 32'(digits), 32'h1230);
      pulse_stop();
      check("t1_cleared", 32'(digits), 32'h0);

      // seconds-tens saturation and a single load cycle
      press_key(9); press_key(0);
      check("t2_entered", 32'(digits), 32'h0090);
      lows_before = loadn_lows;
      start = 1'b1;
      cyc(1);
      check("t2_sat_digits", 32'(digits), 32'h0050);
      check("t2_loadn_low", 32'(loadn), 32'h0);
      check("t2_state_run", 32'(state), 32'd2);
      check("t2_no_count_in_load", 32'(count_en), 32'h0);
      cyc(1);
      check("t2_loadn_high", 32'(loadn), 32'h1);
      check("t2_count_en", 32'(count_en), 32'h1);
      cyc(3);
      start = 1'b0;
      check("t2_single_load", 32'(loadn_lows - lows_before), 32'd1);

      // keys ignored in RUN; timer_done returns to idle
      press_key(4); press_key(8);
      check("t3_keys_ignored", 32'(digits), 32'h0050);
      timer_done = 1'b1;
      cyc(1);
      timer_done = 1'b0;
      check("t3_state_idle", 32'(state), 32'd0);
      check("t3_count_en", 32'(count_en), 32'h0);
      check("t3_digits", 32'(digits), 32'h0);
      check("t3_count", 32'(digit_count), 32'd0);

      // pause / resume / cancel
      press_key(1); press_key(2);
      start = 1'b1; cyc(1); start = 1'b0;
      cyc(3);
      lows_before = loadn_lows;
      stop = 1'b1; cyc(1); stop = 1'b0;
      check("t4_pause", 32'(state), 32'd3);
      check("t4_pause_count_en", 32'(count_en), 32'h0);
      cyc(1);
      start = 1'b1; cyc(1); start = 1'b0;
      check("t4_resume", 32'(state), 32'd2);
      check("t4_resume_count_en", 32'(count_en), 32'h1);
      check("t4_no_reload", 32'(loadn_lows - lows_before), 32'd0);
      cyc(1);
      stop = 1'b1; cyc(1); stop = 1'b0; cyc(1);
      stop = 1'b1; cyc(1); stop = 1'b0;
      check("t4_cancel_state", 32'(state), 32'd0);
      check("t4_cancel_digits", 32'(digits), 32'h0);

      // multi-hot never fires; stop beats start
      press_key(3);
      keypad = 10'b0000100100;
      cyc(HOLD + 2);
      check("t5_multihot", 32'(digits), 32'h0003);
      start = 1'b1; stop = 1'b1;
      cyc(1);
      check("t5_stop_wins", 32'(state), 32'd0);
      check("t5_cleared", 32'(digits), 32'h0);
      start = 1'b0; stop = 1'b0; keypad = '0;
      cyc(HOLD + 2);

      // reset asserted in the middle of the load cycle
      press_key(2);
      start = 1'b1;
      cyc(1);
      check("t6_in_load", 32'(loadn), 32'h0);
      #2 clearn = 1'b0;
      start = 1'b0;
      #1;
      check("t6_loadn_forced", 32'(loadn), 32'h1);
      check("t6_state", 32'(state), 32'd0);
      check("t6_digits", 32'(digits), 32'h0);
      check("t6_count", 32'(digit_count), 32'd0);
      check("t6_count_en", 32'(count_en), 32'h0);
      @(negedge clock);
      clearn = 1'b1;
      cyc(2);

`ifdef KEY_DEBOUNCE_EN
      // a short hold is filtered out; a long hold lands exactly DB+2 edges later
      keypad = 10'b1 << 5;
      cyc(10);
      keypad = '0;
      cyc(DB + 4);
      check("db_glitch", 32'(digit_count), 32'd0);
      keypad = 10'b1 << 5;
      cyc(DB + 1);
      check("db_not_yet", 32'(digit_count), 32'd0);
      cyc(1);
      check("db_landed", 32'(digits), 32'h0005);
      cyc(2);
      keypad = '0;
      cyc(DB + 4);
      pulse_stop();
`endif

      // randomized traffic, checked every cycle by the compare process
      hold = 0;
      for (int n = 0; n < 4000; n++) begin
         if (hold == 0) begin
            r = $urandom_range(0, 9);
            if (r < 5) keypad = '0;
            else if (r < 9) keypad = 10'b1 << $urandom_range(0, 9);
            else keypad = 10'($urandom);
            hold = $urandom_range(1, HOLD_MAX);
         end
         hold--;
         start = ($urandom_range(0, 11) == 0);
         stop = ($urandom_range(0, 29) == 0);
         timer_done = ($urandom_range(0, 24) == 0);
         cyc(1);
      end
      keypad = '0; start = 1'b0; stop = 1'b0; timer_done = 1'b0;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
